// File: rtl/branch_issue_queue_pkg.sv
// Shared types and constants for the branch issue queue: field widths, branch
// command encodings, the queue entry record and the issue-slot record.
package branch_issue_queue_pkg;

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned CMD_W  = 5;
  localparam int unsigned CC_W   = 4;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned DATA_W = 32;

  // Branch command encodings seen on the EX_BRANCH bus
  localparam logic [CMD_W-1:0] EXE_BRANCH_B    = 5'h00;
  localparam logic [CMD_W-1:0] EXE_BRANCH_BL   = 5'h01;
  localparam logic [CMD_W-1:0] EXE_BRANCH_BR   = 5'h02;
  localparam logic [CMD_W-1:0] EXE_BRANCH_BLR  = 5'h03;
  localparam logic [CMD_W-1:0] EXE_BRANCH_SWI  = 5'h04;
  localparam logic [CMD_W-1:0] EXE_BRANCH_IB   = 5'h05;
  localparam logic [CMD_W-1:0] EXE_BRANCH_IDTS = 5'h06;
  localparam logic [CMD_W-1:0] EXE_BRANCH_HALT = 5'h07;

  // Condition code "always"
  localparam logic [CC_W-1:0] CC_AL = 4'hE;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [CMD_W-1:0]  cmd;
    logic [CC_W-1:0]   cc;
    logic [DATA_W-1:0] source;
    logic [DATA_W-1:0] pc;
    logic [FLAG_W-1:0] flag;
    logic              flag_ready;
    logic [TAG_W-1:0]  flag_tag;
  } entry_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [CMD_W-1:0]  cmd;
    logic [CC_W-1:0]   cc;
    logic [FLAG_W-1:0] flag;
    logic [DATA_W-1:0] source;
    logic [DATA_W-1:0] pc;
  } issue_t;

  // True when a flag writeback satisfies an op still waiting on its producer
  function automatic logic flag_wb_hit(input logic             flag_ready,
                                       input logic [TAG_W-1:0] flag_tag,
                                       input logic             wb_valid,
                                       input logic [TAG_W-1:0] wb_tag);
    return wb_valid && !flag_ready && (flag_tag == wb_tag);
  endfunction

endpackage

// File: rtl/branch_issue_queue_entry.sv
// One queue slot: holds a dispatched branch op and snoops the flag writeback
// bus so a waiting op becomes ready as soon as its producer writes back.
module branch_issue_queue_entry
  import branch_issue_queue_pkg::*;
(
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              write,
  input  entry_t            write_data,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [FLAG_W-1:0] wb_data,
  output entry_t            entry
);

  entry_t entry_q, entry_d;

  // Next state: new op on write, then capture a matching writeback so a
  // same-cycle push and writeback land as a ready entry.
  always_comb begin
    entry_d = write ? write_data : entry_q;
    if (flag_wb_hit(entry_d.flag_ready, entry_d.flag_tag, wb_valid, wb_tag)) begin
      entry_d.flag_ready = 1'b1;
      entry_d.flag       = wb_data;
    end
  end

  // Slot storage
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/branch_issue_queue.sv
// In-order issue queue for branch ops feeding the port-0 branch execute stage.
// Ops wait for their condition flags, issue strictly in order into a registered
// EX_BRANCH slot, and the whole queue flushes on iFREE_RESTART.
// Build option BRANCH_ISSUE_QUEUE_BYPASS_EN: a ready op pushed into an empty
// queue with a free slot goes straight to the output register (1-cycle latency).
module branch_issue_queue
  import branch_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              iFREE_RESTART,
  input  logic              iDISPATCH_VALID,
  input  logic [TAG_W-1:0]  iDISPATCH_COMMIT_TAG,
  input  logic [CMD_W-1:0]  iDISPATCH_CMD,
  input  logic [CC_W-1:0]   iDISPATCH_CC,
  input  logic [DATA_W-1:0] iDISPATCH_SOURCE,
  input  logic [DATA_W-1:0] iDISPATCH_PC,
  input  logic              iDISPATCH_FLAG_READY,
  input  logic [FLAG_W-1:0] iDISPATCH_FLAG,
  input  logic [TAG_W-1:0]  iDISPATCH_FLAG_TAG,
  output logic              oDISPATCH_FULL,
  input  logic              iFLAG_WB_VALID,
  input  logic [TAG_W-1:0]  iFLAG_WB_TAG,
  input  logic [FLAG_W-1:0] iFLAG_WB_DATA,
  output logic              oEX_BRANCH_VALID,
  output logic [TAG_W-1:0]  oEX_BRANCH_COMMIT_TAG,
  output logic [CMD_W-1:0]  oEX_BRANCH_CMD,
  output logic [CC_W-1:0]   oEX_BRANCH_CC,
  output logic [FLAG_W-1:0] oEX_BRANCH_FLAG,
  output logic [DATA_W-1:0] oEX_BRANCH_SOURCE,
  output logic [DATA_W-1:0] oEX_BRANCH_PC,
  input  logic              iEX_BRANCH_LOCK
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q;
  logic             out_valid_q;
  issue_t           out_q;

  entry_t           dispatch_entry;
  entry_t           entries [DEPTH];
  entry_t           head_entry;
  issue_t           bypass_issue;
  logic             accept, push, load, bypass;
  logic             transfer, slot_free, head_ready, wb_valid;
  logic             unused_head_flag_tag;

  assign dispatch_entry = '{
    tag:        iDISPATCH_COMMIT_TAG,
    cmd:        iDISPATCH_CMD,
    cc:         iDISPATCH_CC,
    source:     iDISPATCH_SOURCE,
    pc:         iDISPATCH_PC,
    flag:       iDISPATCH_FLAG,
    flag_ready: iDISPATCH_FLAG_READY,
    flag_tag:   iDISPATCH_FLAG_TAG
  };

  // A restart wipes everything, so any writeback in that cycle is discarded
  assign wb_valid   = iFLAG_WB_VALID && !iFREE_RESTART;

  assign transfer   = out_valid_q && !iEX_BRANCH_LOCK;
  // A locked execute stage never takes a new op, even into an empty slot
  assign slot_free  = (!out_valid_q || transfer) && !iEX_BRANCH_LOCK;
  assign head_entry = entries[head_q];
  assign head_ready = (count_q != '0) && head_entry.flag_ready;
  assign accept     = iDISPATCH_VALID && !full_q && !iFREE_RESTART;
  assign load       = !iFREE_RESTART && head_ready && slot_free;

  assign unused_head_flag_tag = ^head_entry.flag_tag;

`ifdef BRANCH_ISSUE_QUEUE_BYPASS_EN
  assign bypass = accept && (count_q == '0) && slot_free &&
                  (iDISPATCH_FLAG_READY ||
                   flag_wb_hit(iDISPATCH_FLAG_READY, iDISPATCH_FLAG_TAG, wb_valid, iFLAG_WB_TAG));
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;

  assign bypass_issue = '{
    tag:    iDISPATCH_COMMIT_TAG,
    cmd:    iDISPATCH_CMD,
    cc:     iDISPATCH_CC,
    flag:   iDISPATCH_FLAG_READY ? iDISPATCH_FLAG : iFLAG_WB_DATA,
    source: iDISPATCH_SOURCE,
    pc:     iDISPATCH_PC
  };

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    branch_issue_queue_entry u_entry (
      .iCLOCK     (iCLOCK),
      .inRESET    (inRESET),
      .write      (push && (tail_q == PTR_W'(i))),
      .write_data (dispatch_entry),
      .wb_valid   (wb_valid),
      .wb_tag     (iFLAG_WB_TAG),
      .wb_data    (iFLAG_WB_DATA),
      .entry      (entries[i])
    );
  end

  // Occupancy: push adds, load removes; both together leave it unchanged
  always_comb begin
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(load);
  end

  // Pointers, count and registered full flag
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (iFREE_RESTART) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (load) head_q <= head_q + PTR_W'(1);
      if (push) tail_q <= tail_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_CNT);
    end
  end

  // EX_BRANCH output register: load from head (or bypass), clear after transfer
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (iFREE_RESTART) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_q.tag   <= head_entry.tag;
      out_q.cmd   <= head_entry.cmd;
      out_q.cc    <= head_entry.cc;
      out_q.flag  <= head_entry.flag;
      out_q.source <= head_entry.source;
      out_q.pc    <= head_entry.pc;
    end else if (bypass) begin
      out_valid_q <= 1'b1;
      out_q       <= bypass_issue;
    end else if (transfer) begin
      out_valid_q <= 1'b0;
    end
  end

  assign oDISPATCH_FULL        = full_q;
  assign oEX_BRANCH_VALID      = out_valid_q;
  assign oEX_BRANCH_COMMIT_TAG = out_q.tag;
  assign oEX_BRANCH_CMD        = out_q.cmd;
  assign oEX_BRANCH_CC         = out_q.cc;
  assign oEX_BRANCH_FLAG       = out_q.flag;
  assign oEX_BRANCH_SOURCE     = out_q.source;
  assign oEX_BRANCH_PC         = out_q.pc;

endmodule

// File: doc/branch_issue_queue.md
Name: branch_issue_queue

Overview:
- In-order issue queue for branch-class ops, directly upstream of the port-0 branch execute stage.
- Accepts dispatched branch ops and holds each until its condition flags are available.
- Presents the head op on the EX_BRANCH bus and honours the execute stage's lock.
- Flushes completely on iFREE_RESTART.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- iCLOCK  in  1  clock.
- inRESET  in  1  reset.
- iFREE_RESTART  in  1  synchronous pipeline flush.
- iDISPATCH_VALID  in  1  push request.
- iDISPATCH_COMMIT_TAG  in  6  commit tag of the op.
- iDISPATCH_CMD  in  5  branch command.
- iDISPATCH_CC  in  4  condition code.
- iDISPATCH_SOURCE  in  32  target, offset or SWI number.
- iDISPATCH_PC  in  32  PC of the op.
- iDISPATCH_FLAG_READY  in  1  flag value is already valid.
- iDISPATCH_FLAG  in  5  flag value, used when FLAG_READY=1.
- iDISPATCH_FLAG_TAG  in  6  producer tag, used when FLAG_READY=0.
- oDISPATCH_FULL  out  1  queue full; no push accepted.
- iFLAG_WB_VALID  in  1  flag writeback strobe.
- iFLAG_WB_TAG  in  6  tag of the flag producer.
- iFLAG_WB_DATA  in  5  written-back flag value.
- oEX_BRANCH_VALID  out  1  issue slot valid.
- oEX_BRANCH_COMMIT_TAG  out  6  issued commit tag.
- oEX_BRANCH_CMD  out  5  issued command.
- oEX_BRANCH_CC  out  4  issued condition code.
- oEX_BRANCH_FLAG  out  5  issued flag value.
- oEX_BRANCH_SOURCE  out  32  issued source.
- oEX_BRANCH_PC  out  32  issued PC.
- iEX_BRANCH_LOCK  in  1  execute stage locked; no transfer.

Interface notes:
- Reset is inRESET, asynchronous, active-low. Clock is iCLOCK.

Behaviour:
- Reset values: all outputs 0, queue empty, pointers and count 0.
- iFREE_RESTART has priority over every other event. In the same cycle it:
  - empties the queue;
  - clears the output register, so oEX_BRANCH_VALID=0 next cycle;
  - ignores any push or writeback arriving that cycle.
- Push:
  - A push is accepted when iDISPATCH_VALID && !oDISPATCH_FULL.
  - The entry is written at the tail and tail increments modulo DEPTH.
  - oDISPATCH_FULL = (count==DEPTH), registered.
  - A push while full is dropped; the bench flags it as a protocol error.
- Entry fields: tag, cmd, cc, source, pc, flag, flag_ready, flag_tag.
- Flag capture:
  - Each cycle, every entry with flag_ready=0 and flag_tag==iFLAG_WB_TAG, while iFLAG_WB_VALID, latches iFLAG_WB_DATA and sets flag_ready.
  - If a pushed op has FLAG_READY=0 and the writeback for its flag tag arrives in the same cycle, it is written with flag_ready=1 and WB data.
- Output register load:
  - Loads from the head when the head is valid and flag_ready, and the slot is free: (!oEX_BRANCH_VALID || transfer).
  - Head increments modulo DEPTH on load.
  - Strict in order: a not-ready head blocks all younger entries.
- Transfer:
  - transfer = oEX_BRANCH_VALID && !iEX_BRANCH_LOCK.
  - With no new load, valid clears the cycle after a transfer.
  - While iEX_BRANCH_LOCK=1, output fields are held stable and nothing is loaded.
- Count:
  - Increments on push, decrements on load.
  - A simultaneous push and load leaves count unchanged, including at count==DEPTH-1.
- Latency (no bypass):
  - Push of a ready op at edge N into an empty queue gives oEX_BRANCH_VALID high from edge N+1 + 1 cycle, i.e. 2 cycles.
  - Throughput is 1 op per cycle when unlocked.
- Lock behaviour:
  - The execute stage holds LOCK high after a taken branch, SWI, IB, IDTS or halt until restart.
  - The queue therefore stalls until iFREE_RESTART; count is preserved until then.
- Wrap-around: pointers wrap silently; full and empty are derived from count, never from pointer equality.

Optional Feature:
- Macro: BRANCH_ISSUE_QUEUE_BYPASS_EN.
- Defined:
  - A push with FLAG_READY=1 (or a same-cycle matching WB) loads directly into the output register in the same edge.
  - Conditions: queue empty, output slot free, no restart.
  - The queue is not written and count is unchanged.
  - Latency becomes 1 cycle.
- Undefined: all ops pass through the queue; latency is 2.

Decomposition:
- Shared package (core.h): EXE_BRANCH_* command encodings, commit-tag width 6, flag width 5, CC width 4, and the entry struct/field widths.
- One natural sub-module, branch_issue_queue_entry: a single entry's storage and flag-capture compare, instantiated DEPTH times.
- Pointers, count and the output register stay in the top module.

Test Plan:
- Ready op pushed (tag 0x05, CC=always, PC 0x100, src 0x40), LOCK=0 -> oEX_BRANCH_VALID=1 two cycles later (one with BYPASS_EN), fields match, valid drops after one cycle.
- Push 4 ready ops -> oDISPATCH_FULL=1 once count reaches 4; 5th push dropped; all 4 issue in tags order 1,2,3,4.
- Head op FLAG_READY=0, flag_tag 0x12; younger op ready -> nothing issues; WB tag 0x12 data 0x0A -> head issues with FLAG=0x0A, then the younger op.
- Hold LOCK=1 with a valid output for 5 cycles -> output fields stable, no head advance; then iFREE_RESTART -> valid=0, count=0, FULL=0 next cycle.
- Push and same-cycle WB matching the pushed flag_tag -> entry ready immediately, issues at the normal latency.
- Push at count=3 with a same-cycle load -> count stays 3, FULL stays 0; pointer wrap over 10 ops preserves order.
